// File: rtl/vector_reduce_sum_pkg.sv
// Shared definitions for the vector reduction stage: FSM encoding and
// fixed-point helpers also used by the element-wise multiplier.
package vector_reduce_sum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Clamp a signed value to the range of a signed 'width'-bit number.
    function automatic logic signed [63:0] sat_to_width(
        input  logic signed [63:0] val,
        input  int                 width,
        output logic               clamped
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        clamped = 1'b0;
        if (val > hi) begin
            clamped = 1'b1;
            return hi;
        end
        if (val < lo) begin
            clamped = 1'b1;
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/vector_reduce_sum_tile_adder.sv
// Combinational sum of TILING consecutive sign-extended cells starting at
// 'index'; cells past the end of the vector contribute zero.
module vector_reduce_sum_tile_adder
    import vector_reduce_sum_pkg::*;
#(
    parameter int VECTOR_LEN = 5,
    parameter int CELL_WIDTH = 10,
    parameter int TILING     = 1,
    parameter int ACC_W      = 14,
    parameter int IDX_W      = 4
) (
    input  logic [VECTOR_LEN*CELL_WIDTH-1:0] vector,
    input  logic [IDX_W-1:0]                 index,
    output logic signed [ACC_W-1:0]          tile_sum
);

    logic signed [ACC_W-1:0] cell_ext [VECTOR_LEN];
    logic signed [ACC_W-1:0] pick;

    always_comb begin
        for (int i = 0; i < VECTOR_LEN; i++) begin
            cell_ext[i] = {{(ACC_W-CELL_WIDTH){vector[i*CELL_WIDTH+CELL_WIDTH-1]}},
                           vector[i*CELL_WIDTH +: CELL_WIDTH]};
        end
    end

    // One mux + adder per tile lane; an index past the end matches no cell.
    always_comb begin
        tile_sum = '0;
        pick     = '0;
        for (int t = 0; t < TILING; t++) begin
            pick = '0;
            for (int i = 0; i < VECTOR_LEN; i++) begin
                if (int'(index) + t == i) pick = cell_ext[i];
            end
            tile_sum = tile_sum + pick;
        end
    end

endmodule

// File: rtl/vector_reduce_sum.sv
// Reduces a packed signed fixed-point vector to one saturated scalar,
// TILING cells per cycle.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SUM   | accumulating one tile of cells per cycle
// DONE  | saturating accumulator into result, raising valid
module vector_reduce_sum
    import vector_reduce_sum_pkg::*;
#(
    parameter int VECTOR_LEN   = 5,
    parameter int CELL_WIDTH   = 10,
    parameter int RESULT_WIDTH = 12,
    parameter int TILING       = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [VECTOR_LEN*CELL_WIDTH-1:0] vector,
    output logic [RESULT_WIDTH-1:0]          result,
    output logic                             valid,
    output logic                             error
);

    localparam int ACC_W = CELL_WIDTH + clog2(VECTOR_LEN) + 1;
    // Wide enough for the index overshoot after a partial last tile.
    localparam int IDX_W = clog2(VECTOR_LEN + TILING) + 1;

    state_t                          state;
    logic [VECTOR_LEN*CELL_WIDTH-1:0] vector_reg;
    logic signed [ACC_W-1:0]         acc;
    logic [IDX_W-1:0]                index;
    logic [IDX_W-1:0]                next_index;
    logic signed [ACC_W-1:0]         tile_sum;
    logic signed [63:0]              acc_wide;
    logic signed [63:0]              sat_val;
    logic                            sat_clamped;
    logic                            unused_sat;

    vector_reduce_sum_tile_adder #(
        .VECTOR_LEN (VECTOR_LEN),
        .CELL_WIDTH (CELL_WIDTH),
        .TILING     (TILING),
        .ACC_W      (ACC_W),
        .IDX_W      (IDX_W)
    ) u_tile_adder (
        .vector   (vector_reg),
        .index    (index),
        .tile_sum (tile_sum)
    );

    assign next_index = index + IDX_W'(TILING);
    assign acc_wide   = {{(64-ACC_W){acc[ACC_W-1]}}, acc};

    always_comb begin
        sat_clamped = 1'b0;
        sat_val     = sat_to_width(acc_wide, RESULT_WIDTH, sat_clamped);
    end

    assign unused_sat = ^sat_val[63:RESULT_WIDTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            vector_reg <= '0;
            acc        <= '0;
            index      <= '0;
            result     <= '0;
            valid      <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vector_reg <= vector;
                        acc        <= '0;
                        index      <= '0;
                        valid      <= 1'b0;
                        error      <= 1'b0;
                        state      <= SUM;
                    end
                end
                SUM: begin
                    acc   <= acc + tile_sum;
                    index <= next_index;
                    if (int'(next_index) >= VECTOR_LEN) state <= DONE;
                end
                DONE: begin
                    result <= sat_val[RESULT_WIDTH-1:0];
                    error  <= sat_clamped;
                    valid  <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
